inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch and issue unit that drives the 4-bit opcode field consumed by the control decoder, plus the register fields consumed by the datapath. It walks a program counter through a synchronous-read instruction memory and presents one instruction per cycle to decode. It honours a stall from downstream and stops on a HALT opcode. It sits between the instruction memory and the control/register-file stage, at the front of the processor.

## Interface

- `IMEM_AW`, default 8: instruction memory address width; the PC is this wide.
- `INST_W`, default 16: instruction width. The format is fixed: [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2/imm.
- `clk`, input, 1: the single clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `start`, input, 1: single-cycle pulse; begins execution from address 0.
- `stall`, input, 1: downstream not ready; hold the current instruction.
- `imem_addr`, output, IMEM_AW: read address; registered to the fetch pointer.
- `imem_en`, output, 1: read enable. When low, the memory holds its output register.
- `imem_rdata`, input, INST_W: read data, valid one cycle after an enabled address.
- `inst`, output, INST_W: instruction presented to decode; `inst[15:12]` feeds the decoder opcode input.
- `inst_valid`, output, 1: `inst` holds a live instruction.
- `inst_pc`, output, IMEM_AW: address of `inst`.
- `halted`, output, 1: a HALT was fetched and execution has stopped.

## Operation

- **Opcodes**
  - 4'b0000–4'b0111 are ALU ops (ADD, SUB, AND, XOR, SLL, SRL, COM, MUL); each is issued unmodified.
  - 4'b1111 is HALT.
  - 4'b1000–4'b1110 are issued as-is; decode treats them as no-write.
- **State IDLE**
  - `imem_en`=0, `fptr`=0.
  - `start` → FETCH0.
- **State FETCH0**
  - `imem_en`=1, `imem_addr`=`fptr`, `fptr`<=`fptr`+1.
  - Next state: RUN.
- **State RUN, `stall`=0**
  - Capture `imem_rdata` into `inst`, with `inst_pc`=`fptr`-1 and `inst_valid`=1.
  - Issue the next read at `fptr`; `fptr`<=`fptr`+1.
- **State RUN, `stall`=1**
  - `imem_en`=0 and `fptr` held.
  - `inst`, `inst_pc` and `inst_valid` are held unchanged.
  - The memory holds its output, so the pending word is not lost.
- **HALT captured in RUN (no stall)**
  - `inst_valid`=0 and `halted`<=1; the HALT word is not issued.
  - `imem_en`=0. Next state: HALT.
- **State HALT**
  - All outputs are held except `inst_valid`=0.
  - `start` → clear `halted`, `fptr`=0, go to FETCH0.
- **`start` while in FETCH0 or RUN**: ignored.
- **PC arithmetic**: modulo 2^IMEM_AW. After address 2^IMEM_AW−1, fetch continues at 0 with no flag.
- **Handshake**: an instruction with `inst_valid`=1 is consumed on the rising edge where `stall`=0. While `stall`=1 it must remain bit-stable.
- **`stall` outside RUN**: no effect.

## Timing

- **Reset**: `rst_n` low asynchronously forces
  - state=IDLE, `fptr`=0, `imem_addr`=0, `imem_en`=0;
  - `inst`=0, `inst_pc`=0, `inst_valid`=0, `halted`=0.
- **Reset mid-run**: any in-flight fetch is discarded; there is no partial issue after release.
- **Start-to-issue latency**: `start` sampled at edge T → FETCH0 in T..T+1 → first `inst_valid`=1 after edge T+2.
- **Throughput**: one instruction per cycle with `stall`=0.
- **Stall recovery**: each stalled cycle delays all later issues by exactly one cycle. The first instruction after `stall` deasserts is the next sequential address, with no bubble and no duplicate.
- **HALT timing**: `halted` rises on the edge that captures the HALT word. The last issued instruction is the one before HALT, and its valid cycle is unaffected.

## Test plan

- **Straight-line program**: reset, load mem[0..3]={ADD,SUB,XOR,HALT}, pulse `start` at cycle 0 → `inst_valid` high for cycles 2–4 with `inst_pc`=0,1,2, then `halted`=1 and `inst_valid`=0 from cycle 5.
- **Stall hold**: assert `stall` for 3 cycles while `inst_pc`=1 → `inst` and `inst_pc` stay bit-stable and `imem_en`=0 throughout. `inst_pc`=2 appears on the first cycle after release, with no skipped or duplicated address.
- **Wrap-around**: IMEM_AW=4, no HALT in memory → `inst_pc` sequence 14, 15, 0, 1 with no gap.
- **Reset mid-run**: drop `rst_n` while `inst_valid`=1 → all outputs are 0 immediately, without waiting for a clock edge. After release the block stays IDLE until `start`.
- **Restart after HALT**: pulse `start` in HALT → `halted` clears and the first instruction reissues from `inst_pc`=0, two cycles later.
- **Ignored start and stall**: pulse `start` during RUN and `stall` during IDLE → no state, PC or output change.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch/issue: walks a PC through a synchronous-read instruction
// memory and presents one instruction per cycle to decode, honouring stall and HALT.
module inst_fetch #(
   parameter int IMEM_AW = 8,
   parameter int INST_W  = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stall,
   output logic [IMEM_AW-1:0] imem_addr,
   output logic               imem_en,
   input  logic [INST_W-1:0]  imem_rdata,
   output logic [INST_W-1:0]  inst,
   output logic               inst_valid,
   output logic [IMEM_AW-1:0] inst_pc,
   output logic               halted
);

   localparam logic [3:0] OP_HALT = 4'hF;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH0,
      S_RUN,
      S_HALT
   } state_t;

   state_t             state_q, state_d;
   logic [IMEM_AW-1:0] fptr_q, fptr_d;
   logic [INST_W-1:0]  inst_q, inst_d;
   logic [IMEM_AW-1:0] inst_pc_q, inst_pc_d;
   logic               inst_valid_q, inst_valid_d;
   logic               halted_q, halted_d;
   logic [3:0]         rdata_op;

   assign rdata_op = imem_rdata[INST_W-1 -: 4];

   always_comb begin
      state_d      = state_q;
      fptr_d       = fptr_q;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;
      inst_valid_d = inst_valid_q;
      halted_d     = halted_q;
      imem_en      = 1'b0;
      case (state_q)
         S_IDLE: begin
            fptr_d = '0;
            if (start) begin
               state_d = S_FETCH0;
            end
         end
         S_FETCH0: begin
            imem_en = 1'b1;
            fptr_d  = fptr_q + IMEM_AW'(1);
            state_d = S_RUN;
         end
         S_RUN: begin
            // While stalled the memory keeps its output, so the pending word survives.
            if (!stall) begin
               if (rdata_op == OP_HALT) begin
                  inst_valid_d = 1'b0;
                  halted_d     = 1'b1;
                  state_d      = S_HALT;
               end else begin
                  inst_d       = imem_rdata;
                  inst_pc_d    = fptr_q - IMEM_AW'(1);
                  inst_valid_d = 1'b1;
                  imem_en      = 1'b1;
                  fptr_d       = fptr_q + IMEM_AW'(1);
               end
            end
         end
         S_HALT: begin
            inst_valid_d = 1'b0;
            if (start) begin
               halted_d = 1'b0;
               fptr_d   = '0;
               state_d  = S_FETCH0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         fptr_q       <= '0;
         inst_q       <= '0;
         inst_pc_q    <= '0;
         inst_valid_q <= 1'b0;
         halted_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         fptr_q       <= fptr_d;
         inst_q       <= inst_d;
         inst_pc_q    <= inst_pc_d;
         inst_valid_q <= inst_valid_d;
         halted_q     <= halted_d;
      end
   end

   assign imem_addr  = fptr_q;
   assign inst       = inst_q;
   assign inst_pc    = inst_pc_q;
   assign inst_valid = inst_valid_q;
   assign halted     = halted_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: transaction-level issue model plus directed programs
// (straight line, stall, wrap, mid-run reset, restart, ignored start/stall).
module tb_inst_fetch;
   localparam int AW = 4;
   localparam int IW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          stall = 1'b0;
   logic [AW-1:0] imem_addr;
   logic          imem_en;
   logic [IW-1:0] imem_rdata = '0;
   logic [IW-1:0] inst;
   logic          inst_valid;
   logic [AW-1:0] inst_pc;
   logic          halted;

   logic [IW-1:0] mem [16];
   int n_pass = 0;
   int n_tot  = 0;

   always #5 clk = ~clk;

   always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

   inst_fetch #(.IMEM_AW(AW), .INST_W(IW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
      .imem_addr(imem_addr), .imem_en(imem_en), .imem_rdata(imem_rdata),
      .inst(inst), .inst_valid(inst_valid), .inst_pc(inst_pc), .halted(halted)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue model: after start, one warm-up edge, then each unstalled edge
   // issues mem[next] and advances, unless the word is HALT.
   bit            m_active = 0;
   int            m_warm   = 0;
   logic [AW-1:0] m_next   = '0;
   logic [IW-1:0] m_inst   = '0;
   logic [AW-1:0] m_pc     = '0;
   bit            m_valid  = 0;
   bit            m_halted = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active = 0; m_warm = 0; m_next = '0; m_inst = '0;
         m_pc = '0; m_valid = 0; m_halted = 0;
      end else if (m_active) begin
         if (m_warm > 0) m_warm = m_warm - 1;
         else if (!stall) begin
            if (mem[m_next][15:12] == 4'hF) begin
               m_valid = 0; m_halted = 1; m_active = 0;
            end else begin
               m_inst = mem[m_next]; m_pc = m_next; m_valid = 1;
               m_next = m_next + 4'd1;
            end
         end
      end else begin
         m_valid = 0;
         if (start) begin
            m_active = 1; m_warm = 1; m_next = '0; m_halted = 0;
         end
      end
   end

   always @(negedge clk) begin
      logic          exp_en;
      logic [AW-1:0] exp_addr;
      exp_en   = m_active && (m_warm > 0 || (!stall && mem[m_next][15:12] != 4'hF));
      exp_addr = ((m_active && m_warm == 0) || m_halted) ? m_next + 4'd1 : '0;
      check("cyc_valid",  32'(inst_valid), 32'(m_valid));
      check("cyc_halted", 32'(halted),     32'(m_halted));
      check("cyc_inst",   32'(inst),       32'(m_inst));
      check("cyc_pc",     32'(inst_pc),    32'(m_pc));
      check("cyc_en",     32'(imem_en),    32'(exp_en));
      check("cyc_addr",   32'(imem_addr),  32'(exp_addr));
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 16'h8000 | 16'(i);
      repeat (2) tick();
      check("rst_valid", 32'(inst_valid), 0);
      check("rst_halted", 32'(halted), 0);
      check("rst_en", 32'(imem_en), 0);
      check("rst_addr", 32'(imem_addr), 0);
      check("rst_inst", 32'(inst), 0);
      rst_n = 1'b1;
      tick();

      // Straight-line program ADD, SUB, XOR, HALT
      mem[0] = 16'h0123; mem[1] = 16'h1456; mem[2] = 16'h3789; mem[3] = 16'hF000;
      pulse_start();
      check("f0_en", 32'(imem_en), 1);
      check("f0_addr", 32'(imem_addr), 0);
      tick();
      check("c1_valid", 32'(inst_valid), 0);
      tick();
      check("c2_valid", 32'(inst_valid), 1);
      check("c2_pc", 32'(inst_pc), 0);
      check("c2_inst", 32'(inst), 32'h0123);
      tick();
      check("c3_pc", 32'(inst_pc), 1);
      check("c3_inst", 32'(inst), 32'h1456);
      tick();
      check("c4_pc", 32'(inst_pc), 2);
      check("c4_inst", 32'(inst), 32'h3789);
      tick();
      check("c5_valid", 32'(inst_valid), 0);
      check("c5_halted", 32'(halted), 1);
      check("c5_en", 32'(imem_en), 0);
      check("c5_inst_held", 32'(inst), 32'h3789);

      // Restart from HALT, stall for three cycles at pc 1, ignored start in RUN
      mem[3] = 16'h2abc; mem[4] = 16'h9def; mem[5] = 16'hF000;
      pulse_start();
      check("rs_halted", 32'(halted), 0);
      tick();
      tick();
      check("rs_pc0", 32'(inst_pc), 0);
      check("rs_valid", 32'(inst_valid), 1);
      tick();
      check("st_pc1", 32'(inst_pc), 1);
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("st_hold_pc", 32'(inst_pc), 1);
         check("st_hold_inst", 32'(inst), 32'h1456);
         check("st_hold_en", 32'(imem_en), 0);
         check("st_hold_valid", 32'(inst_valid), 1);
      end
      stall = 1'b0;
      tick();
      check("st_rel_pc", 32'(inst_pc), 2);
      check("st_rel_inst", 32'(inst), 32'h3789);
      pulse_start();
      check("ign_start_pc", 32'(inst_pc), 3);
      check("ign_start_inst", 32'(inst), 32'h2abc);
      tick();
      check("c_pc4_inst", 32'(inst), 32'h9def);
      tick();
      check("st_halted", 32'(halted), 1);

      // Wrap-around with no HALT in memory
      for (int i = 0; i < 16; i++) mem[i] = 16'h0100 | 16'(i);
      pulse_start();
      repeat (16) tick();
      check("wr_pc14", 32'(inst_pc), 14);
      check("wr_inst14", 32'(inst), 32'h010E);
      tick();
      check("wr_pc15", 32'(inst_pc), 15);
      tick();
      check("wr_pc0", 32'(inst_pc), 0);
      check("wr_inst0", 32'(inst), 32'h0100);
      check("wr_valid", 32'(inst_valid), 1);
      tick();
      check("wr_pc1", 32'(inst_pc), 1);

      // Asynchronous reset while an instruction is valid
      rst_n = 1'b0;
      #1;
      check("ar_valid", 32'(inst_valid), 0);
      check("ar_inst", 32'(inst), 0);
      check("ar_pc", 32'(inst_pc), 0);
      check("ar_en", 32'(imem_en), 0);
      check("ar_addr", 32'(imem_addr), 0);
      check("ar_halted", 32'(halted), 0);
      #1;
      rst_n = 1'b1;

      // Stall while idle does nothing; block waits for start
      stall = 1'b1;
      tick();
      tick();
      check("id_valid", 32'(inst_valid), 0);
      check("id_en", 32'(imem_en), 0);
      check("id_addr", 32'(imem_addr), 0);
      stall = 1'b0;
      tick();
      check("id_still_en", 32'(imem_en), 0);
      pulse_start();
      tick();
      tick();
      check("post_rst_pc", 32'(inst_pc), 0);
      check("post_rst_inst", 32'(inst), 32'h0100);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
